// File: rtl/ecc_scrub_pkg.sv
// Shared types, constants and the saturating-add helper for the ECC scrub scheduler.
package ecc_scrub_pkg;

  localparam int unsigned CntWidthDefault = 16;
  typedef logic [CntWidthDefault-1:0] cnt_t;

  // Smallest tick period; it gives a scrubber time to finish one access
  // before its next trigger can arrive.
  localparam int unsigned MinScrubPeriod = 4;

  // Adds an event count to a counter value and clamps the result at i_max.
  function automatic logic [31:0] sat_add(input logic [31:0] i_a,
                                          input logic [31:0] i_b,
                                          input logic [31:0] i_max);
    logic [32:0] w_sum;
    w_sum = {1'b0, i_a} + {1'b0, i_b};
    if (w_sum > {1'b0, i_max}) begin
      return i_max;
    end else begin
      return w_sum[31:0];
    end
  endfunction

endpackage

// File: rtl/ecc_event_counter.sv
// Saturating event counter with a sticky "count reached threshold" flag.
// clear_i restarts the count from this cycle's increment, so same-cycle
// events survive a clear.
module ecc_event_counter
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned CntWidth = 16,
  parameter int unsigned IncWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [IncWidth-1:0] inc_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                flag_o
);

  localparam logic [31:0] CntMax = (CntWidth >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << CntWidth) - 32'd1);

  logic [CntWidth-1:0] r_cnt;
  logic                r_flag;
  logic [31:0]         w_sum;
  logic [CntWidth-1:0] w_cnt_next;
  logic                w_hit;
  logic                w_flag_next;

  // Next count (cleared base or saturating accumulate) and next sticky flag.
  always_comb begin
    w_sum       = 32'd0;
    w_cnt_next  = {CntWidth{1'b0}};
    w_hit       = 1'b0;
    w_flag_next = 1'b0;
    if (clear_i) begin
      w_sum = sat_add(32'd0, 32'(inc_i), CntMax);
    end else begin
      w_sum = sat_add(32'(r_cnt), 32'(inc_i), CntMax);
    end
    w_cnt_next = CntWidth'(w_sum);
    w_hit      = (thresh_i != {CntWidth{1'b0}}) && (w_cnt_next >= thresh_i);
    if (clear_i) begin
      w_flag_next = w_hit;
    end else begin
      w_flag_next = r_flag | w_hit;
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= {CntWidth{1'b0}};
      r_flag <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_flag <= w_flag_next;
    end
  end

  assign cnt_o  = r_cnt;
  assign flag_o = r_flag;

endmodule

// File: rtl/ecc_scrub_scheduler.sv
// Scrub scheduler: programmable-rate round-robin trigger pulses to the
// per-bank ECC scrubbers, plus event counters and sticky interrupts.
module ecc_scrub_scheduler
  import ecc_scrub_pkg::*;
#(
  parameter int unsigned NumBanks    = 1,
  parameter int unsigned PeriodWidth = 24,
  parameter int unsigned CntWidth    = 16,
  localparam int unsigned BankW      = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_enable_i,
  input  logic [PeriodWidth-1:0] cfg_period_i,
  input  logic [CntWidth-1:0]    cfg_corr_thresh_i,
  input  logic                   clear_i,
  output logic [NumBanks-1:0]    scrub_trigger_o,
  input  logic [NumBanks-1:0]    bit_corrected_i,
  input  logic [NumBanks-1:0]    uncorrectable_i,
  output logic [CntWidth-1:0]    corr_cnt_o,
  output logic [CntWidth-1:0]    uncorr_cnt_o,
  output logic [BankW-1:0]       last_uncorr_bank_o,
  output logic                   irq_uncorr_o,
  output logic                   irq_corr_o
);

  localparam int unsigned PopW = $clog2(NumBanks + 1);
  localparam logic [PeriodWidth-1:0] MinPeriod = PeriodWidth'(MinScrubPeriod);

  logic [PeriodWidth-1:0] r_tick_cnt;
  logic [BankW-1:0]       r_rr;
  logic [NumBanks-1:0]    r_trig;
  logic [BankW-1:0]       r_last_bank;

  logic [PeriodWidth-1:0] w_eff_period;
  logic                   w_tick;
  logic [PeriodWidth-1:0] w_tick_cnt_next;
  logic [BankW-1:0]       w_rr_next;
  logic [NumBanks-1:0]    w_trig_next;
  logic [PopW-1:0]        w_corr_pop;
  logic [PopW-1:0]        w_uncorr_pop;
  logic [BankW-1:0]       w_low_bank;
  logic [BankW-1:0]       w_last_next;

  // Tick decision: >= (not ==) so a shortened period fires immediately.
  always_comb begin
    w_eff_period    = (cfg_period_i < MinPeriod) ? MinPeriod : cfg_period_i;
    w_tick          = cfg_enable_i && (r_tick_cnt >= (w_eff_period - PeriodWidth'(1)));
    w_tick_cnt_next = {PeriodWidth{1'b0}};
    w_rr_next       = r_rr;
    w_trig_next     = {NumBanks{1'b0}};
    if (!cfg_enable_i) begin
      w_tick_cnt_next = {PeriodWidth{1'b0}};
    end else if (w_tick) begin
      w_tick_cnt_next = {PeriodWidth{1'b0}};
      for (int b = 0; b < NumBanks; b++) begin
        w_trig_next[b] = (r_rr == BankW'(b));
      end
      if (r_rr == BankW'(NumBanks - 1)) begin
        w_rr_next = {BankW{1'b0}};
      end else begin
        w_rr_next = r_rr + BankW'(1);
      end
    end else begin
      w_tick_cnt_next = r_tick_cnt + PeriodWidth'(1);
    end
  end

  // Popcounts of the event inputs and lowest-index uncorrectable bank.
  always_comb begin
    w_corr_pop   = {PopW{1'b0}};
    w_uncorr_pop = {PopW{1'b0}};
    w_low_bank   = {BankW{1'b0}};
    for (int b = 0; b < NumBanks; b++) begin
      w_corr_pop   = w_corr_pop + PopW'(bit_corrected_i[b]);
      w_uncorr_pop = w_uncorr_pop + PopW'(uncorrectable_i[b]);
    end
    for (int b = NumBanks - 1; b >= 0; b--) begin
      if (uncorrectable_i[b]) begin
        w_low_bank = BankW'(b);
      end else begin
        w_low_bank = w_low_bank;
      end
    end
    if (|uncorrectable_i) begin
      w_last_next = w_low_bank;
    end else begin
      w_last_next = r_last_bank;
    end
  end

  // Tick counter, round-robin pointer, trigger pulse and last-bank registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tick_cnt  <= {PeriodWidth{1'b0}};
      r_rr        <= {BankW{1'b0}};
      r_trig      <= {NumBanks{1'b0}};
      r_last_bank <= {BankW{1'b0}};
    end else begin
      r_tick_cnt  <= w_tick_cnt_next;
      r_rr        <= w_rr_next;
      r_trig      <= w_trig_next;
      r_last_bank <= w_last_next;
    end
  end

  ecc_event_counter #(
    .CntWidth (CntWidth),
    .IncWidth (PopW)
  ) u_corr_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .inc_i    (w_corr_pop),
    .thresh_i (cfg_corr_thresh_i),
    .cnt_o    (corr_cnt_o),
    .flag_o   (irq_corr_o)
  );

  // Threshold of one: any uncorrectable event raises the sticky flag.
  ecc_event_counter #(
    .CntWidth (CntWidth),
    .IncWidth (PopW)
  ) u_uncorr_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (clear_i),
    .inc_i    (w_uncorr_pop),
    .thresh_i (CntWidth'(1)),
    .cnt_o    (uncorr_cnt_o),
    .flag_o   (irq_uncorr_o)
  );

  assign scrub_trigger_o    = r_trig;
  assign last_uncorr_bank_o = r_last_bank;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Bench for ecc_scrub_scheduler (2 banks, 4-bit counters): a behavioural
// model checked every cycle plus directed literal expectations.
module tb_ecc_scrub_scheduler;

  localparam int NB = 2;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  logic        clk;
  logic        rst_ni;
  logic        cfg_enable;
  logic [23:0] cfg_period;
  logic [3:0]  cfg_thresh;
  logic        clear;
  logic [1:0]  bc;
  logic [1:0]  uc;
  logic [1:0]  trig;
  logic [3:0]  corr;
  logic [3:0]  uncorr;
  logic [0:0]  last_bank;
  logic        irq_c;
  logic        irq_u;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int   m_phase  = 0;
  int   m_bank   = 0;
  int   m_trig   = 0;
  int   m_corr   = 0;
  int   m_uncorr = 0;
  int   m_last   = 0;
  int   m_irq_c  = 0;
  int   m_irq_u  = 0;

  ecc_scrub_scheduler #(
    .NumBanks    (NB),
    .PeriodWidth (24),
    .CntWidth    (CW)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .cfg_enable_i       (cfg_enable),
    .cfg_period_i       (cfg_period),
    .cfg_corr_thresh_i  (cfg_thresh),
    .clear_i            (clear),
    .scrub_trigger_o    (trig),
    .bit_corrected_i    (bc),
    .uncorrectable_i    (uc),
    .corr_cnt_o         (corr),
    .uncorr_cnt_o       (uncorr),
    .last_uncorr_bank_o (last_bank),
    .irq_uncorr_o       (irq_u),
    .irq_corr_o         (irq_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Model: triggers one bank per elapsed period, rotating through the
  // banks; counters are clamped sums; flags are sticky until clear.
  initial begin
    int eff;
    int pc;
    int pu;
    forever begin
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) begin
        m_phase = 0; m_bank = 0; m_trig = 0; m_corr = 0;
        m_uncorr = 0; m_last = 0; m_irq_c = 0; m_irq_u = 0;
      end else begin
        eff = (int'(cfg_period) < 4) ? 4 : int'(cfg_period);
        m_trig = 0;
        if (cfg_enable) begin
          if (m_phase + 1 >= eff) begin
            m_trig  = 1 << m_bank;
            m_bank  = (m_bank + 1) % NB;
            m_phase = 0;
          end else begin
            m_phase = m_phase + 1;
          end
        end else begin
          m_phase = 0;
        end
        pc = $countones(bc);
        pu = $countones(uc);
        if (clear) begin
          m_corr = 0; m_uncorr = 0; m_irq_c = 0; m_irq_u = 0;
        end
        m_corr   = (m_corr + pc > CNT_MAX) ? CNT_MAX : m_corr + pc;
        m_uncorr = (m_uncorr + pu > CNT_MAX) ? CNT_MAX : m_uncorr + pu;
        if (cfg_thresh != 4'd0 && m_corr >= int'(cfg_thresh)) m_irq_c = 1;
        if (pu != 0) begin
          m_irq_u = 1;
          for (int b = NB - 1; b >= 0; b--) begin
            if (uc[b]) m_last = b;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      check("m_trigger",   int'(trig),      m_trig);
      check("m_corr_cnt",  int'(corr),      m_corr);
      check("m_uncorr_cnt",int'(uncorr),    m_uncorr);
      check("m_last_bank", int'(last_bank), m_last);
      check("m_irq_corr",  int'(irq_c),     m_irq_c);
      check("m_irq_uncorr",int'(irq_u),     m_irq_u);
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    rst_ni = 1'b0; cfg_enable = 1'b0; cfg_period = 24'd10; cfg_thresh = 4'd0;
    clear = 1'b0; bc = 2'b00; uc = 2'b00;
    wait_cyc(2);
    check("reset_trig", int'(trig), 0);
    check("reset_corr", int'(corr), 0);
    check("reset_irq",  int'(irq_u) + int'(irq_c), 0);
    rst_ni = 1'b1;
    wait_cyc(1);

    // Period 10: bank0 at 10, bank1 at 20, bank0 at 30, single-cycle pulses
    cfg_enable = 1'b1;
    wait_cyc(9);  check("p10_before_first", int'(trig), 0);
    wait_cyc(1);  check("p10_first_bank0",  int'(trig), 1);
    wait_cyc(1);  check("p10_pulse_width",  int'(trig), 0);
    wait_cyc(9);  check("p10_bank1",        int'(trig), 2);
    wait_cyc(10); check("p10_bank0_again",  int'(trig), 1);

    // Period 1 is treated as 4
    cfg_enable = 1'b0;
    wait_cyc(1);
    cfg_period = 24'd1; cfg_enable = 1'b1;
    wait_cyc(4); check("p1_first",   int'(trig), 2);
    wait_cyc(3); check("p1_gap",     int'(trig), 0);
    wait_cyc(1); check("p1_second",  int'(trig), 1);

    // Shrink period 100 -> 5 with counter at 50
    cfg_enable = 1'b0;
    wait_cyc(1);
    cfg_period = 24'd100; cfg_enable = 1'b1;
    wait_cyc(50);
    cfg_period = 24'd5;
    wait_cyc(1); check("shrink_immediate", int'(trig), 2);
    wait_cyc(4); check("shrink_gap",       int'(trig), 0);
    wait_cyc(1); check("shrink_next",      int'(trig), 1);
    cfg_enable = 1'b0;

    // Corrected threshold 3 with pulses on bank1
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0; cfg_thresh = 4'd3;
    for (int i = 0; i < 3; i++) begin
      bc = 2'b10;
      wait_cyc(1);
      check("thr_corr_cnt", int'(corr), i + 1);
      check("thr_irq_corr", int'(irq_c), (i == 2) ? 1 : 0);
      bc = 2'b00;
      wait_cyc(1);
    end
    check("thr_irq_uncorr_quiet", int'(irq_u), 0);

    // Uncorrectable events and last-bank capture
    uc = 2'b10;
    wait_cyc(1);
    uc = 2'b00;
    check("unc_last_bank1", int'(last_bank), 1);
    check("unc_irq",        int'(irq_u), 1);
    uc = 2'b11;
    wait_cyc(1);
    uc = 2'b00;
    check("unc_cnt_3",      int'(uncorr), 3);
    check("unc_last_low",   int'(last_bank), 0);
    wait_cyc(1);
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    check("clr_corr",   int'(corr), 0);
    check("clr_uncorr", int'(uncorr), 0);
    check("clr_irqs",   int'(irq_u) + int'(irq_c), 0);
    check("clr_last",   int'(last_bank), 0);

    // Saturation at 15, clear with a same-cycle event
    bc = 2'b01;
    wait_cyc(20);
    bc = 2'b00;
    check("sat_corr", int'(corr), 15);
    clear = 1'b1; bc = 2'b01;
    wait_cyc(1);
    clear = 1'b0; bc = 2'b00;
    check("clr_evt_corr", int'(corr), 1);
    check("clr_evt_irq",  int'(irq_c), 0);
    cfg_thresh = 4'd1;
    wait_cyc(1);
    check("lower_thresh_irq", int'(irq_c), 1);
    clear = 1'b1; uc = 2'b01;
    wait_cyc(1);
    clear = 1'b0; uc = 2'b00;
    check("clr_evt_uncorr", int'(uncorr), 1);
    check("clr_evt_irq_u",  int'(irq_u), 1);
    cfg_thresh = 4'd0;

    // Enable dropped mid-period, then reset during a pulse
    cfg_period = 24'd10; cfg_enable = 1'b1;
    wait_cyc(5);
    cfg_enable = 1'b0;
    wait_cyc(20);
    check("dis_no_trig",   int'(trig), 0);
    check("dis_held_cnt",  int'(uncorr), 1);
    cfg_enable = 1'b1;
    wait_cyc(10);
    check("pre_reset_trig", int'(trig), 2);
    rst_ni = 1'b0;
    #1;
    check("rst_trig_cut", int'(trig), 0);
    check("rst_uncorr",   int'(uncorr), 0);
    check("rst_irq_u",    int'(irq_u), 0);
    wait_cyc(1);
    rst_ni = 1'b1;
    wait_cyc(10);
    check("rst_rr_bank0", int'(trig), 1);
    wait_cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_scrub_scheduler.md
Name: ecc_scrub_scheduler

Overview:
Generates the scrub trigger pulses that start one ECC scrub access per tick in each bank's scrubber, and collects the scrubbers' bit_corrected/uncorrectable reports.
Sits directly upstream of the per-bank ECC scrubbers. Drives their scrub-trigger inputs and consumes their status outputs.
Provides a programmable scrub rate, round-robin bank staggering, saturating event counters and a sticky interrupt for software.

Parameters:
NumBanks, 1, number of scrubbers/banks served (>=1)
PeriodWidth, 24, width of the tick period register
CntWidth, 16, width of each saturating event counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_enable_i  in  1  1 = generate triggers
cfg_period_i  in  PeriodWidth  cycles between consecutive triggers (values <4 are treated as 4)
cfg_corr_thresh_i  in  CntWidth  corrected-count interrupt threshold; 0 disables
clear_i  in  1  one-cycle pulse: clear counters and interrupt flags
scrub_trigger_o  out  NumBanks  one-hot trigger pulse, to each scrubber's trigger input
bit_corrected_i  in  NumBanks  per-bank corrected-error pulse from scrubbers
uncorrectable_i  in  NumBanks  per-bank uncorrectable-error pulse from scrubbers
corr_cnt_o  out  CntWidth  saturating total of corrected events
uncorr_cnt_o  out  CntWidth  saturating total of uncorrectable events
last_uncorr_bank_o  out  max(1,$clog2(NumBanks))  bank index of most recent uncorrectable event
irq_uncorr_o  out  1  sticky: any uncorrectable event since clear
irq_corr_o  out  1  sticky: corr_cnt reached threshold

Behaviour:
- Reset: tick counter = 0, rr bank pointer = 0, all outputs = 0.
- Tick counter:
  - When cfg_enable_i = 1, increments each cycle.
  - When it reaches eff_period-1 (eff_period = max(cfg_period_i, 4)): it wraps to 0 and a tick fires in that same cycle.
  - When cfg_enable_i = 0: counter is held at 0 and no ticks fire. Counters and irqs keep their values.
  - If cfg_period_i changes so that counter >= eff_period-1, the tick fires in the next cycle, then the counter wraps.
- Trigger:
  - On a tick cycle, scrub_trigger_o[rr_q] = 1 for exactly one cycle (registered output, one cycle after the tick decision). All other bits are 0.
  - rr_q then advances: (rr_q+1) wraps to 0 after NumBanks-1.
  - Each bank is therefore triggered once per NumBanks*eff_period cycles.
- Dropped triggers: a scrubber that is busy when its pulse arrives ignores it. The scheduler does not retry. The minimum period of 4 guarantees no drop in the absence of interconnect contention.
- Event counting: each cycle, corr_cnt += popcount(bit_corrected_i) and uncorr_cnt += popcount(uncorrectable_i), saturating at 2^CntWidth-1 with no wrap.
- clear_i:
  - In its cycle, counters are loaded with that cycle's popcounts (clear takes priority over old value; same-cycle events are not lost).
  - irq flags are cleared, then re-set if a same-cycle event qualifies.
- last_uncorr_bank_o: updated on any uncorrectable_i bit. With simultaneous bits, the lowest index is recorded. Not affected by clear.
- irq_uncorr_o: set the cycle after any uncorrectable_i bit. Held until clear_i.
- irq_corr_o: set when cfg_corr_thresh_i != 0 and the next corr_cnt >= cfg_corr_thresh_i. Held until clear_i. Lowering the threshold below the current count sets the irq next cycle.
- Reset mid-operation: everything returns to reset values asynchronously. Any pulse in flight is cut.
- Latency from event input to counter/irq output: 1 cycle.

Decomposition:
- Package ecc_scrub_pkg holds:
  - cnt_t type parameterised via localparam default width 16
  - constant MinScrubPeriod = 4
  - sat_add function (saturating add of popcount)
- Sub-module ecc_event_counter: saturating counter + sticky threshold flag with a clear port. Instantiated twice: corrected and uncorrectable (the uncorrectable instance has threshold tied to 1).

Test Plan:
- Reset, NumBanks=2, enable=1, period=10 -> first trigger bank0 at cycle 10 after enable, bank1 at cycle 20, bank0 at 30; every pulse exactly 1 cycle wide.
- period=1 -> triggers spaced 4 cycles apart. Change period 100->5 while counter=50 -> tick next cycle, then every 5 cycles.
- corr_thresh=3; three bit_corrected pulses on bank1 -> corr_cnt_o=3 and irq_corr_o=1 one cycle after third pulse. irq_uncorr_o stays 0.
- uncorrectable_i=2'b11 in one cycle -> uncorr_cnt_o=2, last_uncorr_bank_o=0, irq_uncorr_o=1. A later clear_i alone -> counts 0, irq 0, last bank still 0.
- CntWidth=4, 20 corrected pulses -> corr_cnt_o saturates at 15. clear_i together with bit_corrected_i=1 -> corr_cnt_o=1.
- enable dropped mid-period, then rst_ni asserted while a trigger is high -> no triggers while disabled; on reset scrub_trigger_o=0 immediately, counters 0, rr restarts at bank0.
